// File: rtl/op_share_ctrl_if.sv
// Request, operand, shared-unit and response signals of op_share_ctrl.
// The master side is the controller; the slave side is requesters plus compute unit.
interface op_share_ctrl_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int IW = $clog2(N);

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] a_in;
  logic [N*WIDTH-1:0] b_in;
  logic [N-1:0]       gnt;
  logic               unit_start;
  logic [WIDTH-1:0]   unit_a;
  logic [WIDTH-1:0]   unit_b;
  logic               unit_done;
  logic [WIDTH-1:0]   unit_out;
  logic               rsp_valid;
  logic [IW-1:0]      rsp_id;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_err;
  logic               busy;

  modport master (
    input  req, a_in, b_in, unit_done, unit_out,
    output gnt, unit_start, unit_a, unit_b, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport slave (
    output req, a_in, b_in, unit_done, unit_out,
    input  gnt, unit_start, unit_a, unit_b, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/op_share_ctrl.sv
// Round-robin sharing of one two-operand compute unit among N requesters,
// with start/done sequencing and a timeout watchdog that returns an error response.
module op_share_ctrl #(
  parameter int N       = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  op_share_ctrl_if.master bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_next;
  logic [IW-1:0]    ptr, id;
  logic [IW-1:0]    pick, pick_hi, pick_lo;
  logic             hit_hi, hit_lo;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH-1:0] a_q, b_q, data_q;
  logic [IW-1:0]    rsp_id_q;
  logic             err_q;
  logic [CW-1:0]    cnt;
  logic [N-1:0]     gnt_d;
  logic             capture, cnt_clr, cnt_inc, load_ok, load_err, bump_ptr;

  // Two priority scans: lowest set bit at or above ptr, else lowest set bit overall (wrap).
  always_comb begin
    hit_hi  = 1'b0;
    hit_lo  = 1'b0;
    pick_hi = '0;
    pick_lo = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (bus.req[i] && (i >= 32'(ptr)) && !hit_hi) begin
        hit_hi  = 1'b1;
        pick_hi = IW'(i);
      end
      if (bus.req[i] && !hit_lo) begin
        hit_lo  = 1'b1;
        pick_lo = IW'(i);
      end
    end
    pick = hit_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick == IW'(i)) begin
        a_sel = bus.a_in[i*WIDTH +: WIDTH];
        b_sel = bus.b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    load_ok    = 1'b0;
    load_err   = 1'b0;
    bump_ptr   = 1'b0;
    case (state)
      IDLE: begin
        if (hit_lo) begin
          capture    = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        cnt_clr    = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        // done is checked before the limit so a done on the last cycle wins
        if (bus.unit_done) begin
          load_ok    = 1'b1;
          state_next = RESP;
        end else if (cnt == LAST) begin
          load_err   = 1'b1;
          state_next = RESP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP: begin
        bump_ptr   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      id       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      data_q   <= '0;
      rsp_id_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (capture) begin
        id  <= pick;
        a_q <= a_sel;
        b_q <= b_sel;
      end
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CW'(1);
      if (load_ok) begin
        data_q   <= bus.unit_out;
        err_q    <= 1'b0;
        rsp_id_q <= id;
      end else if (load_err) begin
        data_q   <= '0;
        err_q    <= 1'b1;
        rsp_id_q <= id;
      end
      if (bump_ptr) ptr <= (id == IW'(N - 1)) ? '0 : id + IW'(1);
    end
  end

  always_comb begin
    gnt_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (state == ISSUE && id == IW'(i)) gnt_d[i] = 1'b1;
    end
  end

  assign bus.gnt        = gnt_d;
  assign bus.unit_start = (state == ISSUE);
  assign bus.unit_a     = a_q;
  assign bus.unit_b     = b_q;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = data_q;
  assign bus.rsp_err    = err_q;
  assign bus.busy       = (state != IDLE);
endmodule

// File: doc/op_share_ctrl.md
# op_share_ctrl

Round-robin controller that shares one two-operand compute unit (operands a, b → result out, start/done handshake) among N requesters. It arbitrates pending requests and captures the winner's operands. It then sequences the unit through start, wait and completion, and returns the result tagged with the requester index. A timeout watchdog returns an error response if the unit never signals done.

## Interface
- N, default 4: number of requesters (≥2).
- WIDTH, default 8: operand/result width.
- TIMEOUT, default 15: maximum WAIT cycles before error response (≥2).
- IW, derived, $clog2(N): index width.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- req  in  N  request per requester; held with operands until granted.
- a_in  in  N*WIDTH  operand a; requester i at [i*WIDTH +: WIDTH].
- b_in  in  N*WIDTH  operand b, same packing.
- gnt  out  N  one-hot, one-cycle pulse: operands of that requester captured.
- unit_start  out  1  one-cycle start pulse to shared unit.
- unit_a  out  WIDTH  captured operand a, stable from start until response.
- unit_b  out  WIDTH  captured operand b, same.
- unit_done  in  1  unit completion strobe.
- unit_out  in  WIDTH  unit result, valid with unit_done.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  IW  requester index of response.
- rsp_data  out  WIDTH  result; 0 on error.
- rsp_err  out  1  1 = timeout, valid with rsp_valid.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. All outputs registered or decoded from registered state/latches.
- IDLE: if any req bit is set, select the first set bit searching from ptr upward, wrapping N-1→0. Latch index, a, b. Next state is ISSUE. If no req bit is set, stay in IDLE.
- ISSUE (1 cycle): gnt[id]=1, unit_start=1 → WAIT. The WAIT counter clears to 0.
- WAIT: unit_done sampled only here. When done=1, latch unit_out, set err=0, go to RESP. Otherwise increment the counter. If the counter reaches TIMEOUT-1 with no done, set data=0, err=1, go to RESP. If done arrives on the final timeout cycle, done wins: err=0.
- RESP (1 cycle): rsp_valid=1 with rsp_id/rsp_data/rsp_err. Set ptr = (id+1) mod N → IDLE.
- unit_done in IDLE/ISSUE/RESP ignored; no pending state kept.
- Requester dropping req before gnt: simply not selected; no error.
- rsp_id/rsp_data/rsp_err hold their last value outside rsp_valid.
- unit_a/unit_b hold the last captured operands until the next capture.
- Reset (asserted anytime, including mid-operation): state IDLE, ptr=0, counter 0. gnt, unit_start, rsp_valid, rsp_err, busy are 0. rsp_id, rsp_data, unit_a, unit_b are 0. The in-flight operation is abandoned without a response. A late unit_done after release is ignored (IDLE).

## Timing
- Edge E0 samples req in IDLE. gnt and unit_start are high in cycle E0–E1.
- Unit done asserted in the first WAIT cycle and sampled at E2. rsp_valid is high in cycle E2–E3.
- IDLE re-entered at E3, and the next grant is earliest in cycle E4–E5. Minimum issue-to-issue interval is 4 cycles.
- Latency from unit_done sample to rsp_valid is 1 cycle.
- Timeout: rsp_valid follows exactly TIMEOUT WAIT cycles after unit_start.
- busy rises the cycle after request sampling and falls the cycle after RESP.

## Test plan
- Reset: assert rst=0 mid-run with arbitrary inputs. All outputs are 0 immediately (asynchronously) and stay 0 until release.
- Single request: req=4'b0100, a=3, b=5, unit model returns a+b 2 cycles after start. Expect gnt=4'b0100 for one cycle, unit_start with unit_a=3/unit_b=5, then rsp_valid with rsp_id=2, rsp_data=8, rsp_err=0.
- Fairness: req=4'b1111 held continuously from reset. Grant order is 0,1,2,3,0 with exactly one outstanding op. Then hold req=4'b1001 after granting 3: next grants are 0, 3, 0.
- Timeout: unit never asserts done. rsp_valid arrives 15 WAIT cycles after unit_start with rsp_err=1 and rsp_data=0. A subsequent request completes normally.
- Boundary: done with unit_out=8'hA5 on the 15th WAIT cycle gives rsp_err=0 and rsp_data=8'hA5. unit_done pulsed in IDLE gives no response.
- Reset in WAIT for req[1]: no response is produced. A done pulse after release is ignored. Then with req=4'b1010, the first gnt goes to index 1 (ptr reset to 0).
